// File: rtl/lsu_bus_adapter.sv
`timescale 1ns/1ps
// lsu_bus_adapter: bridges an RV32I load/store unit to a single-beat word bus.
// Generates byte enables and replicated store lanes, extracts/extends load
// lanes, enforces a bus timeout and flags illegal encodings as access faults.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        core request handshake (ready only in IDLE)
//   req_we, req_funct3         store select, RV32I width/sign code
//   req_addr, req_wdata        byte address, store data (rs2)
//   resp_valid/rdata/err       one-cycle completion pulse with load data/fault
//   stall                      core must hold PC and request
//   bus_req/we/addr/wdata/be   registered word-bus command, held until bus_ack
//   bus_ack, bus_rdata         bus completion and read data
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned H/HU/W
// accesses fault without touching the bus; otherwise the offset is aligned.
module lsu_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              bus_req_d, bus_we_d;
  logic [31:0]       bus_addr_d, bus_wdata_d;
  logic [3:0]        bus_be_d;
  logic              resp_valid_d, resp_err_d;
  logic [31:0]       resp_rdata_d;

  // Request decode
  logic        illegal;
  logic        misalign;
  logic [1:0]  req_off;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;
  logic [31:0] load_shift;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign stall     = (state == BUS) || ((state == IDLE) && req_valid);

  // Illegal width codes, and unsigned widths on a store
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = req_we;
      default:                illegal = 1'b0;
    endcase
  end

  // Effective lane offset: halfwords use addr[1], words ignore addr[1:0]
  always_comb begin
    req_off = 2'b00;
    case (req_funct3[1:0])
      2'b00:   req_off = req_addr[1:0];
      2'b01:   req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misaligned halfword/word accesses fault instead of being aligned
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = (req_addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // Byte enables and store-lane replication
  always_comb begin
    req_be    = 4'hF;
    req_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        req_be    = 4'b0001 << req_off;
        req_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be    = 4'b0011 << req_off;
        req_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'hF;
        req_lanes = req_wdata;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension
  assign load_shift = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = load_shift;
    case (funct3_q)
      3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {24'h000000, load_shift[7:0]};
      3'b101:  load_data = {16'h0000, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    funct3_d     = funct3_q;
    off_d        = off_q;
    we_d         = we_q;
    cnt_d        = cnt;
    bus_req_d    = bus_req;
    bus_we_d     = bus_we;
    bus_addr_d   = bus_addr;
    bus_wdata_d  = bus_wdata;
    bus_be_d     = bus_be;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (illegal || misalign) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d     = BUS;
            funct3_d    = req_funct3;
            off_d       = req_off;
            we_d        = req_we;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[31:2], 2'b00};
            bus_wdata_d = req_lanes;
            bus_be_d    = req_be;
          end
        end
      end

      BUS: begin
        // bus_ack wins over a timeout landing in the same cycle
        if (bus_ack) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = we_q ? 32'h0 : load_data;
        end else if (cnt == CNT_LAST) begin
          state_d      = RESP;
          bus_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      funct3_q   <= 3'b000;
      off_q      <= 2'b00;
      we_q       <= 1'b0;
      cnt        <= '0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      bus_be     <= 4'h0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      state      <= state_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      we_q       <= we_d;
      cnt        <= cnt_d;
      bus_req    <= bus_req_d;
      bus_we     <= bus_we_d;
      bus_addr   <= bus_addr_d;
      bus_wdata  <= bus_wdata_d;
      bus_be     <= bus_be_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

endmodule
